// File: rtl/serial_loader_pkg.sv
// Shared types and sizing helpers for the serial word loader.
// Used with or without SERIAL_LOADER_PARITY_CHECK_EN.
package serial_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // The counter must be able to hold WIDTH itself, and is never narrower than one bit.
    function automatic int count_width(input int width);
        return ($clog2(width + 1) > 1) ? $clog2(width + 1) : 1;
    endfunction

    // Count value at which the next accepted bit is the parity bit.
    function automatic int parity_slot(input int width);
        return width;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Serial-in shift register with a bit counter. A clear together with a shift starts a new frame.
// word_next is the value the register takes on the next edge.
module serial_shift_reg
    import serial_loader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word_next,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] base;

    always_comb begin
        base      = clear ? '0 : data;
        word_next = data;
        if (shift_en) begin
            if (MSB_FIRST) begin
                word_next = (base << 1) | WIDTH'(bit_in);
            end else begin
                word_next = (base >> 1) | (WIDTH'(bit_in) << (WIDTH - 1));
            end
        end else if (clear) begin
            word_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= '0;
            count <= '0;
        end else begin
            data <= word_next;
            if (shift_en) begin
                count <= clear ? CW'(1) : count + CW'(1);
            end else if (clear) begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/serial_word_loader.sv
// Deserialises a valid/ready bit stream into WIDTH-bit words and pulses load once per word.
// Define SERIAL_LOADER_PARITY_CHECK_EN to append an even-parity bit per frame and add parity_err.
module serial_word_loader
    import serial_loader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             start,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             load,
    output logic             busy,
    output logic             frame_err
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);
    localparam int CW = count_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             in_frame;
    logic             shift_en;
    logic             clear;
    logic [WIDTH-1:0] word_next;
    logic [CW-1:0]    count;

    assign accept   = bit_valid && bit_ready;
    assign in_frame = accept && (start || state == SHIFT);
    assign clear    = accept && start;

`ifdef SERIAL_LOADER_PARITY_CHECK_EN
    logic parity_hit;
    logic parity_ok;

    // The parity bit is checked against the held word and never shifted in.
    assign parity_hit = accept && !start && (state == SHIFT)
                        && (count == CW'(parity_slot(WIDTH)));
    assign parity_ok  = ~(^{word_next, bit_in});
    assign shift_en   = in_frame && !parity_hit;
`else
    logic data_full;

    assign shift_en = in_frame;

    always_comb begin
        data_full = 1'b0;
        if (accept) begin
            if (start) begin
                data_full = (WIDTH == 1);
            end else if (state == SHIFT) begin
                data_full = (count == CW'(WIDTH - 1));
            end
        end
    end
`endif

    serial_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CW        (CW)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .clear     (clear),
        .bit_in    (bit_in),
        .word_next (word_next),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, SHIFT: begin
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
                if (parity_hit) begin
                    state_next = parity_ok ? LOAD : IDLE;
                end else if (in_frame) begin
                    state_next = SHIFT;
                end
`else
                if (in_frame) begin
                    state_next = data_full ? LOAD : SHIFT;
                end
`endif
            end
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bit_ready = (state != LOAD);
        busy      = (state != IDLE);
        load      = (state == LOAD);
    end

    // A start accepted mid-frame discards the partial word and flags it for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_out   <= '0;
            frame_err  <= 1'b0;
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= clear && (state == SHIFT);
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
            parity_err <= parity_hit && !parity_ok;
            if (parity_hit && parity_ok) begin
                word_out <= word_next;
            end
`else
            if (data_full) begin
                word_out <= word_next;
            end
`endif
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench: an MSB-first and an LSB-first loader share one bit stream.
// Build with SERIAL_LOADER_PARITY_CHECK_EN defined to exercise parity framing.
module tb_serial_word_loader;
    localparam int WIDTH = 8;
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
    localparam int FRAME_PERIOD = WIDTH + 2;
`else
    localparam int FRAME_PERIOD = WIDTH + 1;
`endif

    typedef struct {
        logic [7:0] bits;
        bit         gaps;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       start = 1'b0;
    logic       ready_m, ready_l, load_m, load_l, busy_m, busy_l, ferr_m, ferr_l;
    logic [7:0] word_m, word_l;
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
    logic       perr_m, perr_l;
`endif

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int load_count = 0;
    int ferr_count = 0;
    int last_load_cycle = 0;
    int prev_load_cycle = 0;

    vec_t vecs[6];

    serial_word_loader #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .start     (start),
        .bit_ready (ready_m),
        .word_out  (word_m),
        .load      (load_m),
        .busy      (busy_m),
        .frame_err (ferr_m)
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
        ,
        .parity_err(perr_m)
`endif
    );

    serial_word_loader #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .start     (start),
        .bit_ready (ready_l),
        .word_out  (word_l),
        .load      (load_l),
        .busy      (busy_l),
        .frame_err (ferr_l)
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
        ,
        .parity_err(perr_l)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (load_m) begin
            load_count      <= load_count + 1;
            prev_load_cycle <= last_load_cycle;
            last_load_cycle <= cycle;
        end
        if (ferr_m) ferr_count <= ferr_count + 1;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Offers one bit (optionally after random idle cycles) and returns once it is accepted.
    task automatic send_bit(input logic b, input logic s, input bit gaps, output int held);
        held = 0;
        if (gaps) begin
            for (int g = 0; g < 6; g++) begin
                if ($urandom_range(0, 9) < 3) break;
                bit_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bit_in    = b;
        start     = s;
        bit_valid = 1'b1;
        while (!ready_m && held < 4) begin
            @(posedge clk); #1;
            held++;
        end
        if (!ready_m) check_output("ready_timeout", 32'(ready_m), 32'd1);
        @(posedge clk); #1;
        bit_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bits, input bit gaps, output int first_held);
        int held;
        first_held = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(bits[i], (i == 7), gaps, held);
            if (i == 7) first_held = held;
        end
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
        send_bit(^bits, 1'b0, gaps, held);
`endif
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        int held;
        int loads_before;
        loads_before = load_count;
        send_frame(v.bits, v.gaps, held);
        check_output({tag, "_load_msb"}, 32'(load_m), 32'd1);
        check_output({tag, "_load_lsb"}, 32'(load_l), 32'd1);
        check_output({tag, "_ready_in_load"}, 32'(ready_m), 32'd0);
        check_output({tag, "_word_msb"}, 32'(word_m), 32'(v.exp_msb));
        check_output({tag, "_word_lsb"}, 32'(word_l), 32'(v.exp_lsb));
        @(posedge clk); #1;
        check_output({tag, "_load_after"}, 32'(load_m), 32'd0);
        check_output({tag, "_busy_after"}, 32'(busy_m), 32'd0);
        check_output({tag, "_load_pulses"}, 32'(load_count - loads_before), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int held;
        int h2;
        int loads_before;
        int ferr_before;

        vecs[0] = '{bits: 8'hC0, gaps: 1'b0, exp_msb: 8'hC0, exp_lsb: 8'h03};
        vecs[1] = '{bits: 8'hA5, gaps: 1'b1, exp_msb: 8'hA5, exp_lsb: 8'hA5};
        vecs[2] = '{bits: 8'h01, gaps: 1'b0, exp_msb: 8'h01, exp_lsb: 8'h80};
        vecs[3] = '{bits: 8'h96, gaps: 1'b1, exp_msb: 8'h96, exp_lsb: 8'h69};
        vecs[4] = '{bits: 8'hFF, gaps: 1'b0, exp_msb: 8'hFF, exp_lsb: 8'hFF};
        vecs[5] = '{bits: 8'h3C, gaps: 1'b1, exp_msb: 8'h3C, exp_lsb: 8'h3C};

        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_output("rst_word", 32'(word_m), 32'd0);
        check_output("rst_load", 32'(load_m), 32'd0);
        check_output("rst_busy", 32'(busy_m), 32'd0);
        check_output("rst_ready", 32'(ready_m), 32'd1);
        check_output("rst_ferr", 32'(ferr_m), 32'd0);
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
        check_output("rst_perr", 32'(perr_m), 32'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        // Bits without start in IDLE are dropped.
        send_bit(1'b1, 1'b0, 1'b0, held);
        check_output("idle_drop_busy", 32'(busy_m), 32'd0);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort after 3 bits, then a full frame of ones.
        ferr_before  = ferr_count;
        loads_before = load_count;
        send_bit(1'b1, 1'b1, 1'b0, held);
        send_bit(1'b0, 1'b0, 1'b0, held);
        send_bit(1'b1, 1'b0, 1'b0, held);
        check_output("abort_ferr_before", 32'(ferr_m), 32'd0);
        send_bit(1'b1, 1'b1, 1'b0, held);
        check_output("abort_ferr_msb", 32'(ferr_m), 32'd1);
        check_output("abort_ferr_lsb", 32'(ferr_l), 32'd1);
        check_output("abort_busy", 32'(busy_m), 32'd1);
        send_bit(1'b1, 1'b0, 1'b0, held);
        check_output("abort_ferr_cleared", 32'(ferr_m), 32'd0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, 1'b0, held);
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
        send_bit(1'b0, 1'b0, 1'b0, held);
`endif
        check_output("abort_load", 32'(load_m), 32'd1);
        check_output("abort_word_msb", 32'(word_m), 32'hFF);
        check_output("abort_word_lsb", 32'(word_l), 32'hFF);
        @(posedge clk); #1;
        check_output("abort_ferr_pulses", 32'(ferr_count - ferr_before), 32'd1);
        check_output("abort_load_pulses", 32'(load_count - loads_before), 32'd1);

        // Reset in the middle of a frame, then a clean frame.
        send_bit(1'b1, 1'b1, 1'b0, held);
        send_bit(1'b0, 1'b0, 1'b0, held);
        send_bit(1'b1, 1'b0, 1'b0, held);
        send_bit(1'b0, 1'b0, 1'b0, held);
        #2 rst = 1'b0;
        #1;
        check_output("midrst_word_msb", 32'(word_m), 32'd0);
        check_output("midrst_word_lsb", 32'(word_l), 32'd0);
        check_output("midrst_busy", 32'(busy_m), 32'd0);
        check_output("midrst_ready", 32'(ready_m), 32'd1);
        check_output("midrst_load", 32'(load_m), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(vecs[0], "post_rst");

        // Back-to-back frames at full rate; the next start is offered during LOAD.
        send_frame(8'hA5, 1'b0, held);
        check_output("b2b_load1", 32'(load_m), 32'd1);
        send_frame(8'h3C, 1'b0, h2);
        check_output("b2b_held_in_load", 32'(h2), 32'd1);
        check_output("b2b_load2", 32'(load_m), 32'd1);
        check_output("b2b_word", 32'(word_m), 32'h3C);
        @(posedge clk); #1;
        check_output("b2b_period", 32'(last_load_cycle - prev_load_cycle), 32'(FRAME_PERIOD));

`ifdef SERIAL_LOADER_PARITY_CHECK_EN
        apply_stimulus(vecs[1], "par_good");
        loads_before = load_count;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] w;
            w = 8'h3C;
            send_bit(w[i], (i == 7), 1'b0, held);
        end
        send_bit(1'b1, 1'b0, 1'b0, held);
        check_output("par_bad_perr_msb", 32'(perr_m), 32'd1);
        check_output("par_bad_perr_lsb", 32'(perr_l), 32'd1);
        check_output("par_bad_load", 32'(load_m), 32'd0);
        check_output("par_bad_busy", 32'(busy_m), 32'd0);
        check_output("par_bad_word_msb", 32'(word_m), 32'hA5);
        check_output("par_bad_word_lsb", 32'(word_l), 32'hA5);
        @(posedge clk); #1;
        check_output("par_bad_perr_pulse", 32'(perr_m), 32'd0);
        check_output("par_bad_no_load", 32'(load_count - loads_before), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
